conv_layer_sequencer: RTL and testbench

- Top-level control FSM for the CONV accelerator on a 64x64 image.
- Layer 0: sequences the 3x3 zero-padded convolution window fetches into the external MAC/bias/ReLU datapath, then schedules each result write to L0 memory.
- Layer 1: sequences the 2x2 max-pool reads from L0 into the external comparator, then schedules each write to L1 memory.
- Address and control generation only; all data arithmetic lives in the datapath.

---
 rtl/conv_layer_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer.sv
// Control sequencer for the 3x3 conv + 2x2 max-pool accelerator.
// Generates image/L0/L1 addresses and datapath strobes; no data arithmetic here.
module conv_layer_sequencer #(
  parameter int unsigned IMG_LOG2 = 6,
  parameter int unsigned ADDR_W   = 2 * IMG_LOG2,
  parameter int unsigned MAC_LAT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] iaddr,
  output logic [3:0]        tap_idx,
  output logic              tap_vld,
  output logic              tap_pad,
  output logic              acc_clr,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic              pool_vld,
  output logic              pool_first,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [2:0]        csel
);

  // Tap coordinates carry two guard bits so -1 and IMG appear as out-of-range.
  localparam int unsigned RC_W   = IMG_LOG2 + 2;
  localparam int unsigned PP_W   = 2 * IMG_LOG2 - 2;
  localparam int unsigned HALF   = IMG_LOG2 - 1;
  localparam int unsigned WAIT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_CWR, S_PRD, S_PWAIT, S_PWR, S_DONE
  } state_t;

  function automatic logic [RC_W-1:0] tap_row(input logic [ADDR_W-1:0] pix,
                                               input logic [3:0] k);
    tap_row = RC_W'(pix[ADDR_W-1:IMG_LOG2]) + RC_W'(k / 4'd3) - RC_W'(1);
  endfunction

  function automatic logic [RC_W-1:0] tap_col(input logic [ADDR_W-1:0] pix,
                                               input logic [3:0] k);
    tap_col = RC_W'(pix[IMG_LOG2-1:0]) + RC_W'(k % 4'd3) - RC_W'(1);
  endfunction

  function automatic logic is_pad(input logic [RC_W-1:0] row,
                                  input logic [RC_W-1:0] col);
    is_pad = (|row[RC_W-1:IMG_LOG2]) | (|col[RC_W-1:IMG_LOG2]);
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pix_q, pix_d;
  logic [PP_W-1:0]     pp_q, pp_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;

  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   iaddr_q, iaddr_d;
  logic [3:0]          tap_idx_q, tap_idx_d;
  logic                tap_vld_q, tap_vld_d;
  logic                tap_pad_q, tap_pad_d;
  logic                acc_clr_q, acc_clr_d;
  logic                crd_q, crd_d;
  logic [ADDR_W-1:0]   caddr_rd_q, caddr_rd_d;
  logic                pool_vld_q, pool_vld_d;
  logic                pool_first_q, pool_first_d;
  logic                cwr_q, cwr_d;
  logic [ADDR_W-1:0]   caddr_wr_q, caddr_wr_d;
  logic [2:0]          csel_q, csel_d;

  logic [RC_W-1:0]     nrow, ncol, crow, ccol;

  // Next-cycle tap drives iaddr; current tap drives the delayed tap_* strobes.
  assign nrow = tap_row(pix_d, cnt_d);
  assign ncol = tap_col(pix_d, cnt_d);
  assign crow = tap_row(pix_q, cnt_q);
  assign ccol = tap_col(pix_q, cnt_q);

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      pp_q    <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      pp_q    <= pp_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state and counter sequencing
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    pp_d    = pp_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (ready) begin
          state_d = S_FETCH;
          pix_d   = '0;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        if (cnt_q == 4'd8) begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_W'(MAC_LAT - 1)) state_d = S_CWR;
        else                                 wcnt_d  = wcnt_q + WAIT_W'(1);
      end
      S_CWR: begin
        cnt_d = '0;
        if (&pix_q) begin
          state_d = S_PRD;
          pp_d    = '0;
        end else begin
          state_d = S_FETCH;
          pix_d   = pix_q + ADDR_W'(1);
        end
      end
      S_PRD: begin
        if (cnt_q == 4'd3) state_d = S_PWAIT;
        else               cnt_d   = cnt_q + 4'd1;
      end
      S_PWAIT: state_d = S_PWR;
      S_PWR: begin
        cnt_d = '0;
        if (&pp_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_PRD;
          pp_d    = pp_q + PP_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode, registered so every port comes straight from a flop
  always_comb begin
    busy_d       = 1'b0;
    iaddr_d      = '0;
    tap_idx_d    = '0;
    tap_vld_d    = 1'b0;
    tap_pad_d    = 1'b0;
    acc_clr_d    = 1'b0;
    crd_d        = 1'b0;
    caddr_rd_d   = '0;
    pool_vld_d   = 1'b0;
    pool_first_d = 1'b0;
    cwr_d        = 1'b0;
    caddr_wr_d   = '0;
    csel_d       = CSEL_NONE;

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);

    if (state_d == S_FETCH && !is_pad(nrow, ncol))
      iaddr_d = {nrow[IMG_LOG2-1:0], ncol[IMG_LOG2-1:0]};

    if (state_q == S_FETCH) begin
      tap_vld_d = 1'b1;
      tap_idx_d = cnt_q;
      tap_pad_d = is_pad(crow, ccol);
      acc_clr_d = (cnt_q == 4'd0);
    end

    if (state_q == S_PRD) begin
      pool_vld_d   = 1'b1;
      pool_first_d = (cnt_q == 4'd0);
    end

    unique case (state_d)
      S_CWR: begin
        cwr_d      = 1'b1;
        csel_d     = CSEL_L0;
        caddr_wr_d = pix_d;
      end
      S_PRD: begin
        crd_d      = 1'b1;
        csel_d     = CSEL_L0;
        caddr_rd_d = {pp_d[PP_W-1:HALF], cnt_d[1], pp_d[HALF-1:0], cnt_d[0]};
      end
      S_PWR: begin
        cwr_d      = 1'b1;
        csel_d     = CSEL_L1;
        caddr_wr_d = ADDR_W'(pp_d);
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q       <= 1'b0;
      iaddr_q      <= '0;
      tap_idx_q    <= '0;
      tap_vld_q    <= 1'b0;
      tap_pad_q    <= 1'b0;
      acc_clr_q    <= 1'b0;
      crd_q        <= 1'b0;
      caddr_rd_q   <= '0;
      pool_vld_q   <= 1'b0;
      pool_first_q <= 1'b0;
      cwr_q        <= 1'b0;
      caddr_wr_q   <= '0;
      csel_q       <= CSEL_NONE;
    end else begin
      busy_q       <= busy_d;
      iaddr_q      <= iaddr_d;
      tap_idx_q    <= tap_idx_d;
      tap_vld_q    <= tap_vld_d;
      tap_pad_q    <= tap_pad_d;
      acc_clr_q    <= acc_clr_d;
      crd_q        <= crd_d;
      caddr_rd_q   <= caddr_rd_d;
      pool_vld_q   <= pool_vld_d;
      pool_first_q <= pool_first_d;
      cwr_q        <= cwr_d;
      caddr_wr_q   <= caddr_wr_d;
      csel_q       <= csel_d;
    end
  end

  assign busy       = busy_q;
  assign iaddr      = iaddr_q;
  assign tap_idx    = tap_idx_q;
  assign tap_vld    = tap_vld_q;
  assign tap_pad    = tap_pad_q;
  assign acc_clr    = acc_clr_q;
  assign crd        = crd_q;
  assign caddr_rd   = caddr_rd_q;
  assign pool_vld   = pool_vld_q;
  assign pool_first = pool_first_q;
  assign cwr        = cwr_q;
  assign caddr_wr   = caddr_wr_q;
  assign csel       = csel_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: a job-timeline model computed from the cycle
// offset since the start edge is compared against every DUT output each cycle.
module tb_conv_layer_sequencer;

  localparam int IMG      = 64;
  localparam int MAC_LAT  = 2;
  localparam int PER      = 10 + MAC_LAT;
  localparam int CONV_LEN = IMG * IMG * PER;
  localparam int POOL_PER = 6;
  localparam int JOB_LEN  = CONV_LEN + (IMG / 2) * (IMG / 2) * POOL_PER;

  typedef struct packed {
    logic        busy;
    logic [11:0] iaddr;
    logic [3:0]  tap_idx;
    logic        tap_vld;
    logic        tap_pad;
    logic        acc_clr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic        pool_vld;
    logic        pool_first;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [2:0]  csel;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic [3:0]  tap_idx;
  logic        tap_vld, tap_pad, acc_clr, crd, pool_vld, pool_first, cwr;
  logic [11:0] caddr_rd, caddr_wr;
  logic [2:0]  csel;

  int checks = 0;
  int errors = 0;
  int m_t    = -1;  // cycles since the start edge; -1 means idle
  int n_l0, n_l1;

  conv_layer_sequencer #(.IMG_LOG2(6), .ADDR_W(12), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .reset(rst), .ready(ready), .busy(busy), .iaddr(iaddr),
    .tap_idx(tap_idx), .tap_vld(tap_vld), .tap_pad(tap_pad), .acc_clr(acc_clr),
    .crd(crd), .caddr_rd(caddr_rd), .pool_vld(pool_vld), .pool_first(pool_first),
    .cwr(cwr), .caddr_wr(caddr_wr), .csel(csel)
  );

  always #5 clk = ~clk;

  function automatic logic tap_is_pad(input int r, input int c, input int k);
    int rr = r - 1 + k / 3;
    int cc = c - 1 + k % 3;
    return (rr < 0) || (rr >= IMG) || (cc < 0) || (cc >= IMG);
  endfunction

  function automatic logic [11:0] tap_addr(input int r, input int c, input int k);
    int rr = r - 1 + k / 3;
    int cc = c - 1 + k % 3;
    if (tap_is_pad(r, c, k)) return 12'd0;
    return 12'(rr * IMG + cc);
  endfunction

  function automatic out_t model(input int t);
    out_t o = '0;
    if (t < 0 || t >= JOB_LEN) return o;
    o.busy = 1'b1;
    if (t < CONV_LEN) begin
      int p  = t / PER;
      int ph = t % PER;
      int r  = p / IMG;
      int c  = p % IMG;
      if (ph <= 8) o.iaddr = tap_addr(r, c, ph);
      if (ph >= 1 && ph <= 9) begin
        o.tap_vld = 1'b1;
        o.tap_idx = 4'(ph - 1);
        o.tap_pad = tap_is_pad(r, c, ph - 1);
        o.acc_clr = (ph == 1);
      end
      if (ph == PER - 1) begin
        o.cwr = 1'b1; o.csel = 3'b001; o.caddr_wr = 12'(p);
      end
    end else begin
      int u  = t - CONV_LEN;
      int q  = u / POOL_PER;
      int ph = u % POOL_PER;
      int pr = q / (IMG / 2);
      int pc = q % (IMG / 2);
      if (ph <= 3) begin
        o.crd = 1'b1; o.csel = 3'b001;
        o.caddr_rd = 12'((2 * pr + ph / 2) * IMG + 2 * pc + ph % 2);
      end
      if (ph >= 1 && ph <= 4) begin
        o.pool_vld = 1'b1; o.pool_first = (ph == 1);
      end
      if (ph == 5) begin
        o.cwr = 1'b1; o.csel = 3'b011; o.caddr_wr = 12'(q);
      end
    end
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.busy = busy; o.iaddr = iaddr; o.tap_idx = tap_idx; o.tap_vld = tap_vld;
    o.tap_pad = tap_pad; o.acc_clr = acc_clr; o.crd = crd; o.caddr_rd = caddr_rd;
    o.pool_vld = pool_vld; o.pool_first = pool_first; o.cwr = cwr;
    o.caddr_wr = caddr_wr; o.csel = csel;
    return o;
  endfunction

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, m_t, act, exp);
    end
  endtask

  // Model timeline: the job starts on the edge that sees ready in idle.
  always @(posedge clk or posedge rst) begin
    if (rst)                m_t = -1;
    else if (m_t == -1)     m_t = ready ? 0 : -1;
    else if (m_t == JOB_LEN) m_t = -1;
    else                    m_t = m_t + 1;
  end

  logic [8:0]  pad_first = 9'b001001111;
  logic [8:0]  pad_last  = 9'b111100100;
  int          a327[9]   = '{262, 263, 264, 326, 327, 328, 390, 391, 392};
  int          rd_first[4] = '{0, 1, 64, 65};
  int          rd_last[4]  = '{4030, 4031, 4094, 4095};

  // Per-cycle comparison against the model plus invariants and pinned points
  always @(negedge clk) begin
    out_t exp_o, act_o;
    exp_o = model(m_t);
    act_o = dut_out();
    checks++;
    if (act_o !== exp_o) begin
      errors++;
      $display("FAIL cycle t=%0d actual=%h required=%h", m_t, act_o, exp_o);
    end
    if (cwr && crd) lit("cwr_and_crd", 64'(cwr & crd), 64'd0);
    if (!cwr && !crd) lit("csel_idle", 64'(csel), 64'd0);

    if (m_t == 0) begin n_l0 = 0; n_l1 = 0; end
    if (cwr && csel == 3'b001) n_l0++;
    if (cwr && csel == 3'b011) n_l1++;

    if (m_t == 0) begin
      lit("start_busy", 64'(busy), 64'd1);
      lit("start_iaddr", 64'(iaddr), 64'd0);
    end
    if (m_t >= 1 && m_t <= 9) lit("pix0_pad", 64'(tap_pad), 64'(pad_first[m_t-1]));
    if (m_t == 1) lit("pix0_acc_clr", 64'(acc_clr), 64'd1);
    if (m_t == 11) lit("pix0_wr", {47'd0, cwr, csel, caddr_wr}, {47'd0, 1'b1, 3'b001, 12'd0});
    if (m_t >= 327 * PER && m_t <= 327 * PER + 8)
      lit("pix327_iaddr", 64'(iaddr), 64'(a327[m_t - 327 * PER]));
    if (m_t >= 327 * PER + 1 && m_t <= 327 * PER + 9)
      lit("pix327_pad", 64'(tap_pad), 64'd0);
    if (m_t == 327 * PER + 11)
      lit("pix327_wr", {47'd0, cwr, csel, caddr_wr}, {47'd0, 1'b1, 3'b001, 12'd327});
    if (m_t >= 4095 * PER + 1 && m_t <= 4095 * PER + 9)
      lit("pix4095_pad", 64'(tap_pad), 64'(pad_last[m_t - 4095 * PER - 1]));
    if (m_t >= 49152 && m_t <= 49155) lit("pool0_rd", 64'(caddr_rd), 64'(rd_first[m_t - 49152]));
    if (m_t == 49153) lit("pool0_first", 64'(pool_first), 64'd1);
    if (m_t == 49157) lit("pool0_wr", {47'd0, cwr, csel, caddr_wr}, {47'd0, 1'b1, 3'b011, 12'd0});
    if (m_t >= 55290 && m_t <= 55293) lit("pool1023_rd", 64'(caddr_rd), 64'(rd_last[m_t - 55290]));
    if (m_t == 55295) lit("pool1023_wr", {47'd0, cwr, csel, caddr_wr}, {47'd0, 1'b1, 3'b011, 12'd1023});
    if (m_t == 55296) begin
      lit("done_busy", 64'(busy), 64'd0);
      lit("l0_writes", 64'(n_l0), 64'd4096);
      lit("l1_writes", 64'(n_l1), 64'd1024);
    end
  end

  initial begin
    int target;
    bit done_ok;
    rst   = 1'b1;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    lit("reset_outputs", 64'(dut_out()), 64'd0);
    rst = 1'b0;
    repeat ($urandom_range(2, 5)) @(posedge clk);
    #2 ready = 1'b1;
    @(posedge clk);

    // Aborted job: random ready while busy, reset lands inside pixel 100
    target = 100 * PER + int'($urandom_range(0, PER - 1));
    for (int i = 0; i < 3000 && m_t < target; i++) begin
      #2 ready = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    if (m_t < target) lit("reach_pix100", 64'(m_t), 64'(target));
    #3 rst = 1'b1;
    #1 lit("async_reset_outputs", 64'(dut_out()), 64'd0);
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(posedge clk);

    // Full job: ready random while busy, held high near the end to restart
    #2 ready = 1'b1;
    @(posedge clk);
    done_ok = 1'b0;
    for (int i = 0; i < JOB_LEN + 100; i++) begin
      @(posedge clk);
      #2;
      if (!busy) begin
        done_ok = 1'b1;
        ready   = 1'b1;
        break;
      end
      ready = (m_t > JOB_LEN - 100) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    if (!done_ok) lit("job_end_timeout", 64'(busy), 64'd0);
    @(posedge clk);
    #2 lit("idle_gap_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #2 lit("restart_busy", 64'(busy), 64'd1);
    lit("restart_iaddr", 64'(iaddr), 64'd0);
    repeat (30) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
